// File: rtl/namuru_time_mark_if.sv
// Bus between the time-mark block and its register/control side.
// The master drives TIC, configuration and command strobes and reads back
// the pulse output and status; the slave is the time-mark generator.
interface namuru_time_mark_if #(
  parameter int MC_WIDTH = 16,
  parameter int PW_WIDTH = 24
);
  logic                tic_enable;
  logic [7:0]          tics_per_mark;
  logic [PW_WIDTH-1:0] pulse_width;
  logic                arm;
  logic                disarm;
  logic                status_read;
  logic                time_mark;
  logic                mark_flag;
  logic                overrun;
  logic                running;
  logic [7:0]          tic_index;
  logic [MC_WIDTH-1:0] mark_count;

  modport master (
    output tic_enable, tics_per_mark, pulse_width, arm, disarm, status_read,
    input  time_mark, mark_flag, overrun, running, tic_index, mark_count
  );

  modport slave (
    input  tic_enable, tics_per_mark, pulse_width, arm, disarm, status_read,
    output time_mark, mark_flag, overrun, running, tic_index, mark_count
  );
endinterface

// File: rtl/namuru_time_mark.sv
// TIC-aligned time-mark (1PPS-style) generator.
// Once armed, the first TIC fires a mark; afterwards a mark fires every
// (period shadow + 1) TICs. Each mark drives time_mark high for
// (pulse_width + 1) clocks, bumps mark_count and sets the sticky mark_flag.
// A mark that fires while the pulse is still high retriggers it and sets
// the sticky overrun flag.
module namuru_time_mark #(
  parameter int MC_WIDTH = 16,
  parameter int PW_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rstn,
  namuru_time_mark_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q;
  logic                running_q;
  logic [7:0]          shadow_q;
  logic [7:0]          tic_index_q;
  logic [MC_WIDTH-1:0] mark_count_q;
  logic [PW_WIDTH-1:0] width_q;
  logic                time_mark_q;
  logic                mark_flag_q;
  logic                overrun_q;
  logic                fire_d;

  // A mark fires on a TIC in ARMED, or on the period-closing TIC in RUN;
  // any disarm/arm in the same cycle takes precedence over the TIC.
  always_comb begin
    fire_d = 1'b0;
    if (bus.tic_enable && !bus.disarm && !bus.arm) begin
      if (state_q == ARMED)
        fire_d = 1'b1;
      else if (state_q == RUN && tic_index_q == shadow_q)
        fire_d = 1'b1;
    end
  end

  // Control FSM, period/width counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      tic_index_q  <= 8'd0;
      mark_count_q <= '0;
      width_q      <= '0;
      time_mark_q  <= 1'b0;
      mark_flag_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Pulse timing: count down while high, drop after reaching zero.
      if (time_mark_q) begin
        if (width_q == '0)
          time_mark_q <= 1'b0;
        else
          width_q <= width_q - 1'b1;
      end

      if (bus.status_read)
        mark_flag_q <= 1'b0;

      if (bus.disarm) begin
        if (state_q != IDLE) begin
          state_q     <= IDLE;
          running_q   <= 1'b0;
          time_mark_q <= 1'b0;
          width_q     <= '0;
        end
      end else if (bus.arm) begin
        state_q      <= ARMED;
        running_q    <= 1'b1;
        tic_index_q  <= 8'd0;
        mark_count_q <= '0;
        overrun_q    <= 1'b0;
        time_mark_q  <= 1'b0;
        width_q      <= '0;
      end else if (bus.tic_enable && state_q != IDLE) begin
        if (fire_d) begin
          state_q     <= RUN;
          shadow_q    <= bus.tics_per_mark;
          tic_index_q <= 8'd0;
        end else begin
          tic_index_q <= tic_index_q + 8'd1;
        end
      end

      // Mark fire overrides the countdown and wins over status_read.
      if (fire_d) begin
        width_q      <= bus.pulse_width;
        time_mark_q  <= 1'b1;
        mark_count_q <= mark_count_q + 1'b1;
        mark_flag_q  <= 1'b1;
        if (time_mark_q)
          overrun_q <= 1'b1;
      end
    end
  end

  assign bus.time_mark  = time_mark_q;
  assign bus.mark_flag  = mark_flag_q;
  assign bus.overrun    = overrun_q;
  assign bus.running    = running_q;
  assign bus.tic_index  = tic_index_q;
  assign bus.mark_count = mark_count_q;

endmodule

// File: tb/tb_namuru_time_mark.sv
// Directed testbench for the time-mark generator.
module tb_namuru_time_mark;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  int   shape_err;
  int   cnt_err;
  int   hold_err;

  namuru_time_mark_if #(.MC_WIDTH(16), .PW_WIDTH(24)) bus ();

  namuru_time_mark #(.MC_WIDTH(16), .PW_WIDTH(24)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_strobes();
    bus.tic_enable  = 1'b0;
    bus.arm         = 1'b0;
    bus.disarm      = 1'b0;
    bus.status_read = 1'b0;
  endtask

  // One TIC edge; outputs are sampled right after it.
  task automatic tic();
    bus.tic_enable = 1'b1;
    step();
    bus.tic_enable = 1'b0;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic do_disarm();
    bus.disarm = 1'b1;
    step();
    bus.disarm = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0;
    clr_strobes();
    bus.tics_per_mark = 8'd3;
    bus.pulse_width   = 24'd4;
    step(); step(); step();

    // Reset state
    check("rst_time_mark", {31'd0, bus.time_mark}, 0);
    check("rst_mark_flag", {31'd0, bus.mark_flag}, 0);
    check("rst_overrun",   {31'd0, bus.overrun}, 0);
    check("rst_running",   {31'd0, bus.running}, 0);
    check("rst_tic_index", {24'd0, bus.tic_index}, 0);
    check("rst_mark_count",{16'd0, bus.mark_count}, 0);
    rstn = 1'b1;
    step();

    // IDLE ignores TICs
    tic();
    check("idle_tic_no_mark", {31'd0, bus.time_mark}, 0);

    // Basic marking: TIC every 10 clks, period 4 TICs, 5-cycle pulse
    do_arm();
    check("arm_running", {31'd0, bus.running}, 1);
    shape_err = 0; cnt_err = 0;
    for (int t = 0; t < 100; t++) begin
      tic();
      if (bus.time_mark !== (t % 4 == 0)) shape_err++;
      if (bus.mark_count !== 16'(t / 4 + 1)) cnt_err++;
      if (bus.tic_index !== 8'(t % 4)) cnt_err++;
      for (int j = 1; j < 10; j++) begin
        step();
        if (bus.time_mark !== ((t % 4 == 0) && j <= 4)) shape_err++;
      end
    end
    check("basic_pulse_shape_errs", shape_err, 0);
    check("basic_count_index_errs", cnt_err, 0);
    check("basic_mark_count", {16'd0, bus.mark_count}, 25);
    check("basic_overrun", {31'd0, bus.overrun}, 0);
    check("basic_mark_flag", {31'd0, bus.mark_flag}, 1);

    // Alignment: arm coincident with TIC does not fire
    do_disarm();
    check("disarm_running", {31'd0, bus.running}, 0);
    bus.arm = 1'b1; bus.tic_enable = 1'b1;
    step();
    clr_strobes();
    check("arm_tic_running", {31'd0, bus.running}, 1);
    check("arm_tic_no_mark", {31'd0, bus.time_mark}, 0);
    check("arm_tic_count", {16'd0, bus.mark_count}, 0);
    step(); step();
    tic();
    check("first_mark_high", {31'd0, bus.time_mark}, 1);
    check("first_mark_count", {16'd0, bus.mark_count}, 1);

    // arm + disarm together: disarm wins, stays IDLE
    do_disarm();
    bus.arm = 1'b1; bus.disarm = 1'b1;
    step();
    clr_strobes();
    check("arm_disarm_idle", {31'd0, bus.running}, 0);
    tic();
    check("arm_disarm_no_mark", {31'd0, bus.time_mark}, 0);

    // Overrun: period 1 TIC every 8 clks, 21-cycle pulse
    bus.tics_per_mark = 8'd0;
    bus.pulse_width   = 24'd20;
    do_arm();
    tic();
    check("ovr_first_high", {31'd0, bus.time_mark}, 1);
    check("ovr_first_flag", {31'd0, bus.overrun}, 0);
    hold_err = 0;
    for (int t = 1; t < 5; t++) begin
      for (int j = 1; j < 8; j++) begin
        step();
        if (bus.time_mark !== 1'b1) hold_err++;
      end
      tic();
      if (bus.time_mark !== 1'b1) hold_err++;
      if (t == 1) check("ovr_second_mark", {31'd0, bus.overrun}, 1);
    end
    check("ovr_continuous_high_errs", hold_err, 0);
    check("ovr_mark_count", {16'd0, bus.mark_count}, 5);

    // Flag handshake
    do_disarm();
    bus.status_read = 1'b1; bus.arm = 1'b1;
    bus.tics_per_mark = 8'd3; bus.pulse_width = 24'd1;
    step();
    clr_strobes();
    check("flag_cleared", {31'd0, bus.mark_flag}, 0);
    check("arm_clears_overrun", {31'd0, bus.overrun}, 0);
    bus.tic_enable = 1'b1; bus.status_read = 1'b1;
    step();
    clr_strobes();
    check("flag_set_wins", {31'd0, bus.mark_flag}, 1);
    bus.status_read = 1'b1;
    step();
    clr_strobes();
    check("flag_read_later", {31'd0, bus.mark_flag}, 0);

    // Disarm 2 cycles into a 10-cycle pulse
    bus.pulse_width = 24'd9; bus.tics_per_mark = 8'd0;
    do_arm();
    tic();
    check("dis_pulse_high", {31'd0, bus.time_mark}, 1);
    step();
    do_disarm();
    check("dis_time_mark_low", {31'd0, bus.time_mark}, 0);
    check("dis_count_holds", {16'd0, bus.mark_count}, 1);
    step();
    check("dis_stays_low", {31'd0, bus.time_mark}, 0);

    // Reset mid-pulse
    do_arm();
    tic();
    step();
    rstn = 1'b0;
    step();
    check("rstmid_time_mark", {31'd0, bus.time_mark}, 0);
    check("rstmid_flag", {31'd0, bus.mark_flag}, 0);
    check("rstmid_running", {31'd0, bus.running}, 0);
    check("rstmid_count", {16'd0, bus.mark_count}, 0);
    rstn = 1'b1;
    step();

    // Period change 3 -> 1 mid-period: marks at TICs 1,5,7,9
    bus.tics_per_mark = 8'd3; bus.pulse_width = 24'd0;
    do_arm();
    shape_err = 0;
    for (int t = 1; t <= 9; t++) begin
      if (t == 2) bus.tics_per_mark = 8'd1;
      tic();
      if (bus.time_mark !== (t == 1 || t == 5 || t == 7 || t == 9)) shape_err++;
      step(); step();
    end
    check("period_change_errs", shape_err, 0);
    check("period_change_count", {16'd0, bus.mark_count}, 4);

    // Wrap: a mark on every clock
    bus.tics_per_mark = 8'd0; bus.pulse_width = 24'd0;
    do_arm();
    bus.tic_enable = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check("wrap_pre", {16'd0, bus.mark_count}, 65535);
    step();
    bus.tic_enable = 1'b0;
    check("wrap_zero", {16'd0, bus.mark_count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/namuru_time_mark.md
# namuru_time_mark

Time-mark generator downstream of the time base. Consumes the one-cycle TIC strobe and produces a software-armed, TIC-aligned time-mark pulse (1PPS-style) every N TICs with programmable pulse width. Also exposes a sticky mark flag for the status/interrupt register, a running mark counter, and an overrun flag.

## Interface
- MC_WIDTH, 16, width of the mark counter
- PW_WIDTH, 24, width of the pulse-width register
- clk  in  1  system clock; same clock as the TIC strobe
- rstn  in  1  reset, synchronous, active-low
- tic_enable  in  1  one-cycle TIC strobe from the time base
- tics_per_mark  in  8  the mark period is (tics_per_mark+1) TICs
- pulse_width  in  PW_WIDTH  the mark is high for (pulse_width+1) clk cycles
- arm  in  1  one-cycle request: align to the next TIC and start marking
- disarm  in  1  one-cycle request: stop marking immediately
- status_read  in  1  one-cycle strobe that clears mark_flag
- time_mark  out  1  time-mark output pulse
- mark_flag  out  1  sticky; set at each mark start
- overrun  out  1  sticky; a new mark started while the previous pulse was still high
- running  out  1  high in the ARMED or RUN state
- tic_index  out  8  TICs since the last mark (0..tics_per_mark)
- mark_count  out  MC_WIDTH  marks emitted since arm; wraps at 2^MC_WIDTH

## Operation
- States: IDLE, ARMED, RUN. After reset the block is in IDLE.
- IDLE
  - tic_enable is ignored.
  - On arm: go to ARMED; clear mark_count, tic_index and overrun.
- ARMED
  - On tic_enable: latch tics_per_mark into the period shadow, fire a mark, set tic_index=0, go to RUN.
- RUN
  - On tic_enable with tic_index == shadow: fire a mark, set tic_index=0, reload the shadow from tics_per_mark.
  - On any other tic_enable: tic_index+1.
- Fire a mark:
  - load the width counter with pulse_width; time_mark goes high;
  - mark_count+1, wrapping;
  - set mark_flag.
- Width counter
  - While time_mark is high, decrement each cycle.
  - time_mark drops in the cycle after the counter reads 0.
  - Pulse length is exactly pulse_width+1 cycles.
  - pulse_width is sampled only at mark fire.
- Pulse retrigger: if a mark fires while time_mark is high, reload the width counter, keep time_mark high and set overrun. There is no low gap.
- disarm (ARMED or RUN)
  - Go to IDLE; time_mark goes low next cycle; the width counter clears.
  - mark_count and tic_index hold for readback.
- Priority: disarm beats arm, and both beat tic_enable in the same cycle.
- arm while in ARMED or RUN: re-arm. Go to ARMED, clear the counters, drop time_mark.
- mark_flag
  - Cleared by status_read.
  - If a mark fires in the same cycle as status_read, the set wins and mark_flag stays 1.
  - overrun clears only on arm or reset.
- Changing tics_per_mark mid-period takes effect at the next mark.
- running = (state != IDLE).

## Timing
- All outputs are registered. Reset values: time_mark=0, mark_flag=0, overrun=0, running=0, tic_index=0, mark_count=0. State is IDLE.
- Reset mid-pulse: time_mark is 0 in the cycle after rstn is sampled low.
- Latency from tic_enable at edge k to time_mark=1 and the mark_count update: visible after edge k (1 cycle).
- arm at edge k → running=1 after edge k. A tic_enable in that same cycle is not used for alignment; the first mark needs a later TIC.
- disarm at edge k → running=0 and time_mark=0 after edge k.
- status_read at edge k → mark_flag=0 after edge k, unless a mark fires at edge k.
- Pulse width is independent of TIC spacing. If pulse_width+1 ≥ the mark period in clocks, time_mark stays high continuously and overrun sets.

## Test plan
- Basic marking
  - Stimulus: TIC every 10 clks, tics_per_mark=3, pulse_width=4; arm, then run 100 TICs.
  - Response: time_mark pulses of 5 cycles, one every 40 clks, each starting the cycle after the 1st, 5th, 9th… TIC following arm. mark_count=25; overrun=0.
- Alignment and priority
  - Stimulus: arm in the same cycle as tic_enable.
  - Response: no mark on that TIC; first mark on the next TIC.
  - Stimulus: arm and disarm together.
  - Response: state stays IDLE.
- Overrun
  - Stimulus: tics_per_mark=0, TIC every 8 clks, pulse_width=20.
  - Response: time_mark stays high continuously after the first mark; overrun=1 at the second mark; mark_count increments per TIC.
- Flag handshake
  - Stimulus: status_read coincident with mark fire.
  - Response: mark_flag remains 1.
  - Stimulus: status_read one cycle later.
  - Response: mark_flag=0.
- Disarm and reset mid-pulse
  - Stimulus: disarm 2 cycles into a 10-cycle pulse.
  - Response: time_mark=0 next cycle; mark_count holds.
  - Stimulus: rstn low mid-pulse.
  - Response: all outputs 0 next cycle.
- Period change and wrap
  - Stimulus: change tics_per_mark from 3 to 1 mid-period.
  - Response: the current period completes at 4 TICs; subsequent periods are 2 TICs.
  - Stimulus: run to mark 65536.
  - Response: mark_count wraps to 0.
